dbg_scan: RTL and testbench
===========================

# dbg_scan

Parametrised debug-port sequencer that sits between the CPU's shared memory/register-file debug read port and the board's debug display logic. It steps the port address through a programmable table of up to N_CH channels and holds each address for DWELL cycles. At the end of each dwell it captures the returned word from the register file or memory, as selected per channel, into a snapshot buffer. It replaces fixed, hard-wired address rotation with continuous, single-sweep and single-step modes.

## Interface
- N_CH, 4: number of channels; legal range 2..16.
- AW, 8: debug address width.
- DW, 32: data width.
- DWELL, 1: cycles each address is held before capture; legal range 1..255.
- CW: derived, $clog2(N_CH).

- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_we  in  1  channel-table write strobe.
- cfg_idx  in  CW  channel index to write.
- cfg_addr  in  AW  debug address stored for channel cfg_idx.
- cfg_sel  in  1  data source stored for channel cfg_idx: 0 = rf_data, 1 = m_data.
- mode  in  2  operating mode: 0 idle/abort, 1 continuous, 2 single sweep, 3 step.
- start  in  1  one-cycle pulse that launches a sweep or step (modes 1–3).
- m_rf_addr  out  AW  registered debug read address sent to the CPU.
- rf_data  in  DW  register-file debug read data; combinational from m_rf_addr.
- m_data  in  DW  memory debug read data; combinational from m_rf_addr.
- rd_idx  in  CW  snapshot read index.
- rd_data  out  DW  combinational snapshot[rd_idx]; 0 if rd_idx ≥ N_CH.
- rd_valid  out  1  valid[rd_idx]; 0 if rd_idx ≥ N_CH.
- busy  out  1  high while the FSM is in RUN.
- sweep_done  out  1  one-cycle pulse when the capture of channel N_CH-1 occurs.

## Operation
- State: FSM {IDLE, RUN}, channel pointer ch, dwell counter dcnt (8 bit), table addr[N_CH]/sel[N_CH], snapshot snap[N_CH], valid[N_CH].
- Reset values:
  - FSM = IDLE, ch = 0, dcnt = 0.
  - addr[i] = i, sel[i] = 0.
  - snap = 0, valid = 0.
  - m_rf_addr = 0, busy = 0, sweep_done = 0.
- IDLE:
  - m_rf_addr holds its last value.
  - start with mode ≠ 0 causes: valid cleared (modes 1/2 only), ch = 0 (modes 1/2 only), dcnt = 0, FSM → RUN, and m_rf_addr = addr[ch].
  - In mode 3, ch keeps its value across steps, so each start advances to the next channel.
- RUN, each cycle:
  - If dcnt < DWELL-1, increment dcnt.
  - Otherwise capture: snap[ch] ← (sel[ch] ? m_data : rf_data), valid[ch] ← 1, dcnt ← 0.
- Advance after a capture, with ch_next = ch+1, wrapping to 0 after N_CH-1:
  - Mode 1: ch = ch_next and m_rf_addr = addr[ch_next]; remain in RUN.
  - Mode 2: same advance; on wrap to 0, FSM → IDLE.
  - Mode 3: ch = ch_next and m_rf_addr = addr[ch_next]; FSM → IDLE after every capture.
- sweep_done pulses in the cycle following any capture of channel N_CH-1, in every mode.
- mode = 0 sampled in RUN: FSM → IDLE immediately with no capture; ch, snap and valid are kept.
- A mode change between nonzero values is applied at the next capture boundary.
- start while RUN is ignored.
- cfg_we writes the table in every state.
  - If in RUN and cfg_idx == ch: m_rf_addr ← cfg_addr on the same edge, dcnt ← 0, and that channel's dwell restarts.
  - A table write never alters snap or valid.
- Simultaneous start and cfg_we in IDLE: the table write wins for addressing. m_rf_addr uses the cfg_addr value when cfg_idx == the launch channel.

## Timing
- m_rf_addr is registered. The data inputs are sampled on the edge that ends the DWELL-th cycle the address has been stable.
- Launch latency: start at edge k gives m_rf_addr valid after edge k. The first capture is at edge k+DWELL.
- Full sweep, starting from the first capture edge: N_CH·DWELL cycles. sweep_done is high for the cycle after edge k+N_CH·DWELL.
- busy rises the cycle after start and falls the cycle after the final capture or abort.
- rd_data/rd_valid reflect a capture in the cycle after the capture edge.
- Asynchronous rst mid-sweep returns every output to its reset value immediately, without waiting for a clock edge.

## Test plan
- Default table, N_CH=4, DWELL=1, mode 1, one start pulse:
  - m_rf_addr sequence is 0,1,2,3,0,… one per cycle.
  - sweep_done pulses every 4 cycles.
- Table {8,9,3,4}, all sel=0, DWELL=3, mode 2, with rf_data driven as addr·16:
  - After 12 cycles, snap = {128,144,48,64} and all valid bits are 1.
  - busy then drops and m_rf_addr holds 8.
- Mode 3, sel[1]=1, m_data=0xDEADBEEF:
  - Each start captures exactly one channel: first start → ch0, second start → ch1.
  - snap[1] = 0xDEADBEEF and busy lasts DWELL cycles per step.
- Mode 1, DWELL=4: write cfg_idx = current ch with cfg_addr=0x55 at dcnt=2.
  - m_rf_addr becomes 0x55 next cycle.
  - Capture happens 4 cycles later, not 2.
- Drive mode 0 and then rst mid-sweep:
  - Abort leaves snap intact, with busy low next cycle.
  - rst clears snap and valid immediately, and the address table returns to {0,1,2,3}.
- rd_idx = 5 with N_CH = 5 (max index 4) → rd_data = 0 and rd_valid = 0.

Source files
------------

// File: rtl/dbg_scan.sv
// dbg_scan: walks the shared debug read port through a channel table,
// holds each address for DWELL cycles, then snapshots the selected data.
//
// state | meaning
// IDLE  | port address parked, waiting for start with a nonzero mode
// RUN   | dwelling on the current channel, capturing at dwell end
module dbg_scan #(
  parameter int N_CH  = 4,
  parameter int AW    = 8,
  parameter int DW    = 32,
  parameter int DWELL = 1,
  localparam int CW   = $clog2(N_CH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [CW-1:0] cfg_idx,
  input  logic [AW-1:0] cfg_addr,
  input  logic          cfg_sel,
  input  logic [1:0]    mode,
  input  logic          start,
  output logic [AW-1:0] m_rf_addr,
  input  logic [DW-1:0] rf_data,
  input  logic [DW-1:0] m_data,
  input  logic [CW-1:0] rd_idx,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          busy,
  output logic          sweep_done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CW-1:0] LAST     = CW'(N_CH - 1);
  localparam logic [7:0]    DWELL_M1 = 8'(DWELL - 1);

  state_t              state, state_nxt;
  logic [CW-1:0]       ch, ch_inc, launch_ch;
  logic [7:0]          dcnt;
  logic [AW-1:0]       tbl_addr [N_CH];
  logic                tbl_sel  [N_CH];
  logic [DW-1:0]       snap     [N_CH];
  logic [N_CH-1:0]     valid;
  logic                launch, retarget, count, capture;
  logic                cur_sel;
  logic [AW-1:0]       launch_addr, next_addr;
  logic [DW-1:0]       cap_data;
  logic [DW-1:0]       snap_ext  [2**CW];
  logic                valid_ext [2**CW];

  assign ch_inc    = (ch == LAST) ? '0 : ch + 1'b1;
  // step mode resumes where the last step left off; sweeps restart at 0
  assign launch_ch = (mode == 2'd3) ? ch : '0;
  assign busy      = (state == RUN);

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state and per-cycle action decode; a retarget of the live
  // channel takes priority over its capture so stale data is never sampled
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    retarget  = 1'b0;
    count     = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (start && mode != 2'd0) begin
          launch    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (mode == 2'd0) begin
          state_nxt = IDLE;
        end else if (cfg_we && cfg_idx == ch) begin
          retarget = 1'b1;
        end else if (dcnt < DWELL_M1) begin
          count = 1'b1;
        end else begin
          capture = 1'b1;
          if (mode == 2'd3 || (mode == 2'd2 && ch == LAST)) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // table lookups; a same-cycle table write bypasses into the new address
  always_comb begin
    cur_sel     = 1'b0;
    launch_addr = '0;
    next_addr   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (ch == CW'(i))        cur_sel     = tbl_sel[i];
      if (launch_ch == CW'(i)) launch_addr = tbl_addr[i];
      if (ch_inc == CW'(i))    next_addr   = tbl_addr[i];
    end
    if (cfg_we && cfg_idx == launch_ch) launch_addr = cfg_addr;
    if (cfg_we && cfg_idx == ch_inc)    next_addr   = cfg_addr;
  end

  assign cap_data = cur_sel ? m_data : rf_data;

  // datapath: table, pointer, dwell counter, port address, snapshot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch         <= '0;
      dcnt       <= '0;
      m_rf_addr  <= '0;
      sweep_done <= 1'b0;
      valid      <= '0;
      for (int i = 0; i < N_CH; i++) begin
        tbl_addr[i] <= AW'(i);
        tbl_sel[i]  <= 1'b0;
        snap[i]     <= '0;
      end
    end else begin
      sweep_done <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        if (cfg_we && cfg_idx == CW'(i)) begin
          tbl_addr[i] <= cfg_addr;
          tbl_sel[i]  <= cfg_sel;
        end
      end
      if (launch) begin
        ch        <= launch_ch;
        dcnt      <= '0;
        m_rf_addr <= launch_addr;
        if (mode != 2'd3) valid <= '0;
      end
      if (retarget) begin
        m_rf_addr <= cfg_addr;
        dcnt      <= '0;
      end
      if (count) dcnt <= dcnt + 8'd1;
      if (capture) begin
        for (int i = 0; i < N_CH; i++) begin
          if (ch == CW'(i)) begin
            snap[i]  <= cap_data;
            valid[i] <= 1'b1;
          end
        end
        dcnt       <= '0;
        ch         <= ch_inc;
        m_rf_addr  <= next_addr;
        sweep_done <= (ch == LAST);
      end
    end
  end

  // pad the snapshot out to the full index range so out-of-range reads give 0
  for (genvar g = 0; g < 2**CW; g++) begin : g_ext
    if (g < N_CH) begin : g_live
      assign snap_ext[g]  = snap[g];
      assign valid_ext[g] = valid[g];
    end else begin : g_pad
      assign snap_ext[g]  = '0;
      assign valid_ext[g] = 1'b0;
    end
  end

  assign rd_data  = snap_ext[rd_idx];
  assign rd_valid = valid_ext[rd_idx];

endmodule

// File: tb/tb_dbg_scan.sv
// Directed bench for dbg_scan using three parameterisations:
//   A: N_CH=4 DWELL=1 (continuous sweep, abort, reset, step mode)
//   B: N_CH=4 DWELL=3 (single sweep over a programmed table)
//   C: N_CH=5 DWELL=4 (live retarget, out-of-range read index)
module tb_dbg_scan;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // instance A
  logic       a_cfg_we, a_cfg_sel, a_start, a_rd_valid, a_busy, a_done;
  logic [1:0] a_cfg_idx, a_rd_idx, a_mode;
  logic [7:0] a_cfg_addr, a_addr;
  logic [31:0] a_rf, a_m, a_rd_data;
  // instance B
  logic       b_cfg_we, b_cfg_sel, b_start, b_rd_valid, b_busy, b_done;
  logic [1:0] b_cfg_idx, b_rd_idx, b_mode;
  logic [7:0] b_cfg_addr, b_addr;
  logic [31:0] b_rf, b_m, b_rd_data;
  // instance C
  logic       c_cfg_we, c_cfg_sel, c_start, c_rd_valid, c_busy, c_done;
  logic [2:0] c_cfg_idx, c_rd_idx;
  logic [1:0] c_mode;
  logic [7:0] c_cfg_addr, c_addr;
  logic [31:0] c_rf, c_m, c_rd_data;

  // register file model: word at address a reads as a*16
  assign a_rf = {20'h0, a_addr, 4'h0};
  assign b_rf = {20'h0, b_addr, 4'h0};
  assign c_rf = {20'h0, c_addr, 4'h0};

  logic [7:0]  b_tbl  [4] = '{8'd8, 8'd9, 8'd3, 8'd4};
  logic [31:0] b_snap [4] = '{32'd128, 32'd144, 32'd48, 32'd64};

  dbg_scan #(.N_CH(4), .AW(8), .DW(32), .DWELL(1)) u_a (
    .clk(clk), .rst(rst), .cfg_we(a_cfg_we), .cfg_idx(a_cfg_idx),
    .cfg_addr(a_cfg_addr), .cfg_sel(a_cfg_sel), .mode(a_mode), .start(a_start),
    .m_rf_addr(a_addr), .rf_data(a_rf), .m_data(a_m), .rd_idx(a_rd_idx),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .busy(a_busy), .sweep_done(a_done));

  dbg_scan #(.N_CH(4), .AW(8), .DW(32), .DWELL(3)) u_b (
    .clk(clk), .rst(rst), .cfg_we(b_cfg_we), .cfg_idx(b_cfg_idx),
    .cfg_addr(b_cfg_addr), .cfg_sel(b_cfg_sel), .mode(b_mode), .start(b_start),
    .m_rf_addr(b_addr), .rf_data(b_rf), .m_data(b_m), .rd_idx(b_rd_idx),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .busy(b_busy), .sweep_done(b_done));

  dbg_scan #(.N_CH(5), .AW(8), .DW(32), .DWELL(4)) u_c (
    .clk(clk), .rst(rst), .cfg_we(c_cfg_we), .cfg_idx(c_cfg_idx),
    .cfg_addr(c_cfg_addr), .cfg_sel(c_cfg_sel), .mode(c_mode), .start(c_start),
    .m_rf_addr(c_addr), .rf_data(c_rf), .m_data(c_m), .rd_idx(c_rd_idx),
    .rd_data(c_rd_data), .rd_valid(c_rd_valid), .busy(c_busy), .sweep_done(c_done));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd_a(input int i);
    a_rd_idx = 2'(i);
    #1;
  endtask

  task automatic rd_b(input int i);
    b_rd_idx = 2'(i);
    #1;
  endtask

  task automatic rd_c(input int i);
    c_rd_idx = 3'(i);
    #1;
  endtask

  initial begin
    a_cfg_we = 0; a_cfg_sel = 0; a_start = 0; a_cfg_idx = 0; a_rd_idx = 0; a_mode = 0;
    a_cfg_addr = 0; a_m = 32'hDEADBEEF;
    b_cfg_we = 0; b_cfg_sel = 0; b_start = 0; b_cfg_idx = 0; b_rd_idx = 0; b_mode = 0;
    b_cfg_addr = 0; b_m = 32'h0;
    c_cfg_we = 0; c_cfg_sel = 0; c_start = 0; c_cfg_idx = 0; c_rd_idx = 0; c_mode = 0;
    c_cfg_addr = 0; c_m = 32'h0;

    #12 rst = 1'b0;
    step(1);
    check("reset_addr", a_addr, 0);
    check("reset_busy", a_busy, 0);
    check("reset_done", a_done, 0);
    check("reset_valid", a_rd_valid, 0);

    // A: continuous sweep over the default table
    a_mode = 2'd1; a_start = 1'b1;
    step(1);
    a_start = 1'b0;
    check("a_launch_addr", a_addr, 0);
    check("a_launch_busy", a_busy, 1);
    for (int j = 1; j <= 8; j++) begin
      step(1);
      check($sformatf("a_seq_addr_%0d", j), a_addr, 32'(j % 4));
      check($sformatf("a_seq_done_%0d", j), a_done, (j % 4 == 0) ? 32'd1 : 32'd0);
    end

    // A: abort keeps the snapshot
    a_mode = 2'd0;
    step(1);
    check("a_abort_busy", a_busy, 0);
    check("a_abort_addr", a_addr, 0);
    for (int i = 0; i < 4; i++) begin
      rd_a(i);
      check($sformatf("a_abort_snap_%0d", i), a_rd_data, 32'(i * 16));
      check($sformatf("a_abort_valid_%0d", i), a_rd_valid, 1);
    end

    // A: launch with a simultaneous table write to the launch channel, then reset
    a_mode = 2'd1; a_start = 1'b1;
    a_cfg_we = 1'b1; a_cfg_idx = 2'd0; a_cfg_addr = 8'h40;
    step(1);
    a_start = 1'b0; a_cfg_we = 1'b0;
    check("a_bypass_addr", a_addr, 32'h40);
    step(1);
    check("a_post_bypass_addr", a_addr, 1);
    rd_a(0);
    check("a_bypass_snap", a_rd_data, 32'h400);
    check("a_bypass_valid", a_rd_valid, 1);
    rd_a(1);
    check("a_relaunch_cleared", a_rd_valid, 0);
    step(1);
    check("a_pre_rst_addr", a_addr, 2);
    rst = 1'b1;
    #1;
    check("a_rst_addr", a_addr, 0);
    check("a_rst_busy", a_busy, 0);
    rd_a(0);
    check("a_rst_snap", a_rd_data, 0);
    check("a_rst_valid", a_rd_valid, 0);
    rst = 1'b0;

    // A: step mode, channel 1 sourced from memory data
    step(1);
    a_cfg_we = 1'b1; a_cfg_idx = 2'd1; a_cfg_addr = 8'd1; a_cfg_sel = 1'b1;
    step(1);
    a_cfg_we = 1'b0; a_cfg_sel = 1'b0;
    a_mode = 2'd3; a_start = 1'b1;
    step(1);
    a_start = 1'b0;
    check("a_step1_addr", a_addr, 0);
    check("a_step1_busy", a_busy, 1);
    step(1);
    check("a_step1_idle", a_busy, 0);
    check("a_step1_next_addr", a_addr, 1);
    rd_a(0);
    check("a_step1_valid0", a_rd_valid, 1);
    rd_a(1);
    check("a_step1_valid1", a_rd_valid, 0);
    a_start = 1'b1;
    step(1);
    a_start = 1'b0;
    check("a_step2_addr", a_addr, 1);
    check("a_step2_busy", a_busy, 1);
    step(1);
    check("a_step2_idle", a_busy, 0);
    check("a_step2_next_addr", a_addr, 2);
    check("a_step2_done", a_done, 0);
    rd_a(1);
    check("a_step2_snap", a_rd_data, 32'hDEADBEEF);
    check("a_step2_valid", a_rd_valid, 1);
    a_mode = 2'd0;

    // B: program table, single sweep with DWELL=3
    for (int i = 0; i < 4; i++) begin
      b_cfg_we = 1'b1; b_cfg_idx = 2'(i); b_cfg_addr = b_tbl[i];
      step(1);
    end
    b_cfg_we = 1'b0;
    b_mode = 2'd2; b_start = 1'b1;
    step(1);
    b_start = 1'b0;
    check("b_launch_addr", b_addr, 8);
    check("b_launch_busy", b_busy, 1);
    step(2);
    check("b_dwell_hold", b_addr, 8);
    step(1);
    check("b_first_advance", b_addr, 9);
    step(8);
    check("b_pre_end_busy", b_busy, 1);
    check("b_pre_end_addr", b_addr, 4);
    check("b_pre_end_done", b_done, 0);
    step(1);
    check("b_end_busy", b_busy, 0);
    check("b_end_done", b_done, 1);
    check("b_end_addr", b_addr, 8);
    for (int i = 0; i < 4; i++) begin
      rd_b(i);
      check($sformatf("b_snap_%0d", i), b_rd_data, b_snap[i]);
      check($sformatf("b_valid_%0d", i), b_rd_valid, 1);
    end
    step(1);
    check("b_done_clear", b_done, 0);
    check("b_idle_addr", b_addr, 8);
    check("b_idle_busy", b_busy, 0);

    // C: retarget the live channel mid-dwell
    c_mode = 2'd1; c_start = 1'b1;
    step(1);
    c_start = 1'b0;
    check("c_launch_addr", c_addr, 0);
    step(2);
    check("c_pre_write_addr", c_addr, 0);
    c_cfg_we = 1'b1; c_cfg_idx = 3'd0; c_cfg_addr = 8'h55;
    step(1);
    c_cfg_we = 1'b0;
    check("c_retarget_addr", c_addr, 32'h55);
    step(3);
    check("c_dwell_restart_addr", c_addr, 32'h55);
    rd_c(0);
    check("c_no_early_capture", c_rd_valid, 0);
    step(1);
    check("c_capture_advance", c_addr, 1);
    rd_c(0);
    check("c_capture_snap", c_rd_data, 32'h550);
    check("c_capture_valid", c_rd_valid, 1);
    rd_c(5);
    check("c_oob_data", c_rd_data, 0);
    check("c_oob_valid", c_rd_valid, 0);
    c_mode = 2'd0;
    step(1);
    check("c_abort_busy", c_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
